// File: rtl/zuss_control.sv
// zuss_control: multi-cycle FETCH/DECODE/EXEC sequencer for the ZUSS datapath.
// It fetches over a req/ack port, decodes into register-file/ALU controls and owns the PC.
module zuss_control #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter logic [4:0]      CMP_OP   = 5'b00001
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [4:0]      r_addr1,
    output logic [4:0]      r_addr2,
    output logic [4:0]      w_addr,
    output logic [4:0]      op,
    output logic            we,
    input  logic            zr,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [4:0] OP_NOP  = 5'h1C;
    localparam logic [4:0] OP_BZ   = 5'h1D;
    localparam logic [4:0] OP_JMP  = 5'h1E;
    localparam logic [4:0] OP_HALT = 5'h1F;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [4:0]      ir_op_q, ir_op_d;
    logic [11:0]     ir_imm_q, ir_imm_d;
    logic            imem_req_q, imem_req_d;
    logic [4:0]      r_addr1_q, r_addr1_d;
    logic [4:0]      r_addr2_q, r_addr2_d;
    logic [4:0]      w_addr_q, w_addr_d;
    logic [4:0]      op_q, op_d;
    logic            we_q, we_d;
    logic            halted_q, halted_d;

    function automatic logic is_alu(input logic [4:0] opc);
        return (opc < OP_NOP);
    endfunction

    // BZ drives the compare op so the datapath raises zr on equal operands.
    function automatic logic [4:0] dp_op(input logic [4:0] opc);
        logic [4:0] res;
        if (is_alu(opc)) begin
            res = opc;
        end else if (opc == OP_BZ) begin
            res = CMP_OP;
        end else begin
            res = 5'd0;
        end
        return res;
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_op_d    = ir_op_q;
        ir_imm_d   = ir_imm_q;
        imem_req_d = imem_req_q;
        r_addr1_d  = r_addr1_q;
        r_addr2_d  = r_addr2_q;
        w_addr_d   = w_addr_q;
        op_d       = op_q;
        we_d       = 1'b0;
        halted_d   = halted_q;

        case (state_q)
            ST_FETCH: begin
                imem_req_d = 1'b1;
                // The request flop is low for one cycle after reset; an ack then is not for us.
                if (imem_req_q && imem_ack) begin
                    ir_op_d    = imem_data[31:27];
                    ir_imm_d   = imem_data[11:0];
                    w_addr_d   = imem_data[26:22];
                    r_addr1_d  = imem_data[21:17];
                    r_addr2_d  = imem_data[16:12];
                    op_d       = dp_op(imem_data[31:27]);
                    imem_req_d = 1'b0;
                    state_d    = ST_DECODE;
                end else begin
                    state_d    = ST_FETCH;
                end
            end
            ST_DECODE: begin
                we_d    = is_alu(ir_op_q);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                imem_req_d = 1'b1;
                state_d    = ST_FETCH;
                case (ir_op_q)
                    OP_BZ: begin
                        if (zr) begin
                            pc_d = pc_q + PC_W'($signed(ir_imm_q));
                        end else begin
                            pc_d = pc_q + PC_W'(1'b1);
                        end
                    end
                    OP_JMP: begin
                        pc_d = PC_W'(ir_imm_q);
                    end
                    OP_HALT: begin
                        imem_req_d = 1'b0;
                        halted_d   = 1'b1;
                        state_d    = ST_HALT;
                    end
                    default: begin
                        pc_d = pc_q + PC_W'(1'b1);
                    end
                endcase
            end
            ST_HALT: begin
                imem_req_d = 1'b0;
                halted_d   = 1'b1;
                state_d    = ST_HALT;
            end
            default: begin
                imem_req_d = 1'b0;
                state_d    = ST_FETCH;
            end
        endcase
    end

    // State and registered-output flops with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ir_op_q    <= 5'd0;
            ir_imm_q   <= 12'd0;
            imem_req_q <= 1'b0;
            r_addr1_q  <= 5'd0;
            r_addr2_q  <= 5'd0;
            w_addr_q   <= 5'd0;
            op_q       <= 5'd0;
            we_q       <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_op_q    <= ir_op_d;
            ir_imm_q   <= ir_imm_d;
            imem_req_q <= imem_req_d;
            r_addr1_q  <= r_addr1_d;
            r_addr2_q  <= r_addr2_d;
            w_addr_q   <= w_addr_d;
            op_q       <= op_d;
            we_q       <= we_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign r_addr1   = r_addr1_q;
    assign r_addr2   = r_addr2_q;
    assign w_addr    = w_addr_q;
    assign op        = op_q;
    assign we        = we_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule
